// File: rtl/irqck_pkg.sv
// Shared definitions for the multi-channel interrupt stimulus generator:
// register offsets, channel mode encoding and the PRBS31 advance function.
package irqck_pkg;

    localparam logic [1:0] REG_LIMIT_CNT = 2'd0;
    localparam logic [1:0] REG_ACK       = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_PERIOD    = 2'd3;

    typedef enum logic {
        MODE_RANDOM   = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    // Advance a Fibonacci PRBS31 (x^31 + x^28 + 1) by eight shifts so every
    // random draw uses a fresh byte of the sequence.
    function automatic logic [30:0] prbs31_step8(input logic [30:0] s);
        logic [30:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[29:0], r[30] ^ r[27]};
        end
        return r;
    endfunction

endpackage

// File: rtl/irqck_chan.sv
// One interrupt channel: control registers, PRBS31 source, periodic
// down-counter, pending flag and raised-interrupt counter.
module irqck_chan
    import irqck_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter logic [30:0] SEED  = 31'h00000001
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        wr_i,
    input  logic [1:0]  reg_i,
    input  logic [15:0] data_i,
    input  logic [1:0]  rd_reg_i,
    output logic [15:0] rdata_o,
    output logic        pending_o
);

    logic             pending;
    logic             en;
    mode_e            mode;
    logic [7:0]       limit;
    logic [15:0]      period;
    logic [15:0]      dcnt;
    logic [CNT_W-1:0] cnt;
    logic [30:0]      lfsr;

    logic eligible;
    logic raise;

    // A raise is decided from state at the start of the cycle, so a
    // concurrent ctrl write cannot influence it and an ack can never collide
    // with a raise (a raise needs pending already clear).
    always_comb begin
        eligible = !pending && en;
        raise    = 1'b0;
        if (eligible) begin
            if (mode == MODE_RANDOM) begin
                raise = (limit >= lfsr[7:0]);
            end else begin
                raise = (dcnt == 16'd0);
            end
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en     <= 1'b0;
            mode   <= MODE_RANDOM;
            limit  <= 8'd0;
            period <= 16'd0;
        end else if (wr_i) begin
            case (reg_i)
                REG_LIMIT_CNT: limit <= data_i[7:0];
                REG_CTRL: begin
                    en   <= data_i[0];
                    mode <= mode_e'(data_i[1]);
                end
                REG_PERIOD:    period <= data_i;
                default: ;
            endcase
        end
    end

    // Pending flag and wrapping interrupt counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else if (raise) begin
            pending <= 1'b1;
            cnt     <= cnt + CNT_W'(1);
        end else if (wr_i && (reg_i == REG_ACK)) begin
            pending <= 1'b0;
        end
    end

    // Random source only moves on eligible random-mode cycles.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr <= SEED;
        end else if (eligible && (mode == MODE_RANDOM)) begin
            lfsr <= prbs31_step8(lfsr);
        end
    end

    // Periodic down-counter; a period write reloads it at once and wins over
    // the decrement/reload of the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dcnt <= 16'd0;
        end else if (wr_i && (reg_i == REG_PERIOD)) begin
            dcnt <= data_i;
        end else if (eligible && (mode == MODE_PERIODIC)) begin
            if (dcnt == 16'd0) begin
                dcnt <= period;
            end else begin
                dcnt <= dcnt - 16'd1;
            end
        end
    end

    // Register read view for the captured register offset.
    always_comb begin
        rdata_o = 16'h0000;
        case (rd_reg_i)
            REG_LIMIT_CNT: rdata_o[CNT_W-1:0] = cnt;
            REG_ACK:       rdata_o[0] = pending;
            REG_CTRL:      rdata_o[1:0] = {mode, en};
            REG_PERIOD:    rdata_o = period;
            default:       rdata_o = 16'h0000;
        endcase
    end

    assign pending_o = pending;

endmodule

// File: rtl/irqck_multi.sv
// Multi-channel interrupt stimulus generator on the uC peripheral bus:
// address decode, captured read address, read mux and interrupt OR.
module irqck_multi
    import irqck_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter logic [30:0] PRBS31_INIT = 31'h00000001,
    parameter int          CNT_W       = 16,
    localparam int         CH_W        = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                sel_i,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [CH_W+1:0]     addr_i,
    input  logic [15:0]         data_i,
    output logic [15:0]         data_o,
    output logic [CHANNELS-1:0] irq_o,
    output logic                irq_any_o
);

    logic [CH_W-1:0]     wr_ch;
    logic [CHANNELS-1:0] wr_hit;
    logic [CH_W+1:0]     rd_addr;
    logic [CH_W-1:0]     rd_ch;
    logic [15:0]         ch_rdata [CHANNELS];

    assign wr_ch = addr_i[CH_W+1:2];
    assign rd_ch = rd_addr[CH_W+1:2];

    // Write decode; channel numbers beyond CHANNELS match nothing.
    always_comb begin
        wr_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_i && write_i && (wr_ch == CH_W'(c))) begin
                wr_hit[c] = 1'b1;
            end
        end
    end

    // Capture the read address; data follows from live state next cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_addr <= '0;
        end else if (sel_i && read_i) begin
            rd_addr <= addr_i;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        irqck_chan #(
            .CNT_W (CNT_W),
            .SEED  (PRBS31_INIT ^ 31'(c + 1))
        ) u_chan (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .wr_i      (wr_hit[c]),
            .reg_i     (addr_i[1:0]),
            .data_i    (data_i),
            .rd_reg_i  (rd_addr[1:0]),
            .rdata_o   (ch_rdata[c]),
            .pending_o (irq_o[c])
        );
    end

    // Read mux; unpopulated channel numbers read as zero.
    always_comb begin
        data_o = 16'h0000;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CH_W'(c)) begin
                data_o = ch_rdata[c];
            end
        end
    end

    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_irqck_multi.sv
// Scoreboard bench for irqck_multi (5 channels, 4-bit counters).
module tb_irqck_multi;
    import irqck_pkg::*;

    localparam int NCH = 5;
    localparam int CW  = 4;

    logic           clk_i   = 1'b0;
    logic           rstn_i  = 1'b0;
    logic           sel_i   = 1'b0;
    logic           read_i  = 1'b0;
    logic           write_i = 1'b0;
    logic [4:0]     addr_i  = '0;
    logic [15:0]    data_i  = '0;
    logic [15:0]    data_o;
    logic [NCH-1:0] irq_o;
    logic           irq_any_o;

    irqck_multi #(
        .CHANNELS    (NCH),
        .PRBS31_INIT (31'h00000001),
        .CNT_W       (CW)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .sel_i     (sel_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .irq_o     (irq_o),
        .irq_any_o (irq_any_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] rd_q [$];
    string       rd_n [$];
    logic [5:0]  irq_q [$];
    string       irq_n [$];
    int          vecs = 0;
    int          miss = 0;
    logic        rd_acc = 1'b0;

    always @(posedge clk_i) rd_acc <= sel_i & read_i;

    // Monitor: read data after every accepted read, interrupt lines whenever
    // an expectation is queued.
    always @(negedge clk_i) begin
        logic [15:0] e16;
        logic [5:0]  e6;
        string       n;
        if (rd_acc) begin
            if (rd_q.size() == 0) begin
                miss++;
                $display("FAIL rd_unexpected: data_o=%h with no expectation", data_o);
            end else begin
                e16 = rd_q.pop_front();
                n   = rd_n.pop_front();
                vecs++;
                if (data_o !== e16) begin
                    miss++;
                    $display("FAIL %s: data_o=%h expected %h", n, data_o, e16);
                end
            end
        end
        if (irq_q.size() > 0) begin
            e6 = irq_q.pop_front();
            n  = irq_n.pop_front();
            vecs++;
            if ({irq_any_o, irq_o} !== e6) begin
                miss++;
                $display("FAIL %s: {any,irq}=%b expected %b", n, {irq_any_o, irq_o}, e6);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int ch, input logic [1:0] rg, input logic [15:0] d);
        sel_i = 1'b1; write_i = 1'b1; addr_i = {3'(ch), rg}; data_i = d;
        tick();
        sel_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [1:0] rg, input logic [15:0] exp, input string n);
        rd_q.push_back(exp);
        rd_n.push_back(n);
        sel_i = 1'b1; read_i = 1'b1; addr_i = {3'(ch), rg};
        tick();
        sel_i = 1'b0; read_i = 1'b0;
    endtask

    task automatic chk_irq(input logic [NCH-1:0] v, input string n);
        irq_q.push_back({|v, v});
        irq_n.push_back(n);
    endtask

    // Reference PRBS31: x^31 + x^28 + 1, eight shifts per draw.
    function automatic logic [30:0] ref_step8(input logic [30:0] s);
        logic [30:0] r;
        logic        fb;
        r = s;
        for (int k = 0; k < 8; k++) begin
            fb = r[30] ^ r[27];
            r  = (r << 1) | {30'd0, fb};
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [30:0] lfsr_m;
        logic        pend_m;
        int          elig;
        int          raises;

        // Reset state
        tick();
        tick();
        chk_irq('0, "rst_irq");
        tick();
        rstn_i = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int rg = 0; rg < 4; rg++) begin
                rd(ch, 2'(rg), 16'h0000, "rst_reg");
            end
        end

        // Random mode, limit 255 fires every eligible cycle
        wr(0, REG_LIMIT_CNT, 16'h00FF);
        wr(0, REG_CTRL, 16'h0001);
        chk_irq(5'b00000, "t2_pre");
        tick();
        chk_irq(5'b00001, "t2_raise");
        rd(0, REG_LIMIT_CNT, 16'd1, "t2_cnt1");
        rd(0, REG_ACK, 16'd1, "t2_pend");
        rd(0, REG_CTRL, 16'd1, "t2_ctrl");
        for (int i = 0; i < 10; i++) begin
            wr(0, REG_ACK, 16'h0000);
            chk_irq(5'b00000, "t2_ack");
            tick();
            chk_irq(5'b00001, "t2_refire");
        end
        rd(0, REG_LIMIT_CNT, 16'd11, "t2_cnt11");
        wr(0, REG_CTRL, 16'h0000);
        wr(0, REG_ACK, 16'h0000);
        tick();
        chk_irq(5'b00000, "t2_off");

        // Periodic mode, period 3 then 0
        wr(1, REG_PERIOD, 16'd3);
        rd(1, REG_PERIOD, 16'd3, "t3_period");
        wr(1, REG_CTRL, 16'h0003);
        chk_irq(5'b00000, "t3_wait");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_irq(5'b00000, "t3_wait");
        end
        tick();
        chk_irq(5'b00010, "t3_raise");
        rd(1, REG_CTRL, 16'd3, "t3_ctrl");
        wr(1, REG_ACK, 16'h0000);
        chk_irq(5'b00000, "t3_acked");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_irq(5'b00000, "t3_idle");
        end
        tick();
        chk_irq(5'b00010, "t3_reraise");
        wr(1, REG_PERIOD, 16'd0);
        for (int i = 0; i < 2; i++) begin
            wr(1, REG_ACK, 16'h0000);
            chk_irq(5'b00000, "t3_p0_ack");
            tick();
            chk_irq(5'b00010, "t3_p0_raise");
        end
        rd(1, REG_LIMIT_CNT, 16'd4, "t3_cnt");
        wr(1, REG_CTRL, 16'h0000);
        wr(1, REG_ACK, 16'h0000);
        chk_irq(5'b00000, "t3_off");

        // Random mode limit 0 against the reference LFSR
        lfsr_m = 31'h00000001 ^ 31'd3;
        pend_m = 1'b0;
        elig   = 0;
        raises = 0;
        wr(2, REG_CTRL, 16'h0001);
        while (elig < 10000 || !pend_m) begin
            if (pend_m) begin
                wr(2, REG_ACK, 16'h0000);
                pend_m = 1'b0;
            end else begin
                tick();
                elig++;
                if (lfsr_m[7:0] == 8'd0) begin
                    pend_m = 1'b1;
                    raises++;
                end
                lfsr_m = ref_step8(lfsr_m);
            end
            chk_irq(pend_m ? 5'b00100 : 5'b00000, "t4_rand");
        end
        rd(2, REG_LIMIT_CNT, 16'(raises % 16), "t4_cnt");
        wr(2, REG_CTRL, 16'h0000);
        chk_irq(5'b00100, "t4_en0_hold");
        for (int i = 0; i < 3; i++) tick();
        chk_irq(5'b00100, "t4_en0_hold");
        wr(2, REG_ACK, 16'h0000);
        chk_irq(5'b00000, "t4_acked");
        tick();
        chk_irq(5'b00000, "t4_quiet");

        // Simultaneous raises on ch0 and ch3
        wr(0, REG_PERIOD, 16'd2);
        wr(3, REG_PERIOD, 16'd1);
        wr(0, REG_CTRL, 16'h0003);
        wr(3, REG_CTRL, 16'h0003);
        chk_irq(5'b00000, "t5_wait");
        tick();
        chk_irq(5'b00000, "t5_wait");
        tick();
        chk_irq(5'b01001, "t5_both");
        wr(0, REG_CTRL, 16'h0000);
        chk_irq(5'b01001, "t5_hold");
        wr(3, REG_CTRL, 16'h0000);
        chk_irq(5'b01001, "t5_hold");
        wr(0, REG_ACK, 16'h0000);
        chk_irq(5'b01000, "t5_ack0");
        wr(3, REG_ACK, 16'h0000);
        chk_irq(5'b00000, "t5_ack3");

        // Unpopulated channel numbers
        rd(5, REG_LIMIT_CNT, 16'h0000, "t5_oor_cnt");
        rd(7, REG_CTRL, 16'h0000, "t5_oor_ctrl");
        wr(5, REG_PERIOD, 16'h1234);
        wr(5, REG_CTRL, 16'h0003);
        wr(6, REG_CTRL, 16'h0001);
        rd(1, REG_PERIOD, 16'h0000, "t5_noalias_p");
        rd(5, REG_PERIOD, 16'h0000, "t5_oor_period");
        rd(3, REG_LIMIT_CNT, 16'd1, "t5_cnt3");
        chk_irq(5'b00000, "t5_oor_irq");

        // Counter wrap at CNT_W=4
        wr(4, REG_LIMIT_CNT, 16'h00FF);
        wr(4, REG_CTRL, 16'h0001);
        tick();
        chk_irq(5'b10000, "t6_raise");
        for (int i = 0; i < 16; i++) begin
            wr(4, REG_ACK, 16'h0000);
            tick();
        end
        chk_irq(5'b10000, "t6_raise17");
        rd(4, REG_LIMIT_CNT, 16'd1, "t6_wrap");
        wr(4, REG_CTRL, 16'h0000);
        wr(4, REG_ACK, 16'h0000);
        chk_irq(5'b00000, "t6_off");

        // Asynchronous reset mid periodic count
        wr(1, REG_PERIOD, 16'd5);
        wr(1, REG_CTRL, 16'h0003);
        tick();
        tick();
        #2;
        rstn_i = 1'b0;
        chk_irq(5'b00000, "t6_in_rst");
        tick();
        tick();
        rstn_i = 1'b1;
        rd(1, REG_PERIOD, 16'h0000, "t6_rst_period");
        rd(1, REG_CTRL, 16'h0000, "t6_rst_ctrl");
        rd(1, REG_LIMIT_CNT, 16'h0000, "t6_rst_cnt1");
        rd(0, REG_LIMIT_CNT, 16'h0000, "t6_rst_cnt0");
        rd(4, REG_LIMIT_CNT, 16'h0000, "t6_rst_cnt4");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_irq(5'b00000, "t6_post_rst");
        end

        tick();
        tick();
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            miss++;
            $display("FAIL drain: %0d reads and %0d irq checks left, expected 0", rd_q.size(), irq_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
